// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: merges two toggle-handshake clients onto one
// 16-bit SDRAM controller port, one access outstanding at a time.
module sdram_port_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic [21:0] a_addr,
  input  logic        a_req,
  input  logic [1:0]  a_ds,
  input  logic [15:0] a_din,
  input  logic        a_we,
  output logic        a_req_ack,
  output logic [15:0] a_dout,

  input  logic [21:0] b_addr,
  input  logic        b_req,
  input  logic [1:0]  b_ds,
  input  logic [15:0] b_din,
  input  logic        b_we,
  output logic        b_req_ack,
  output logic [15:0] b_dout,

  output logic [21:0] mem_addr,
  output logic        mem_req,
  output logic [1:0]  mem_ds,
  output logic [15:0] mem_din,
  output logic        mem_we,
  input  logic        mem_req_ack,
  input  logic [15:0] mem_dout
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   a_pend;
  logic   b_pend;
  logic   any_pend;
  logic   pick_b;
  logic   mem_done;

  assign a_pend   = a_req != a_req_ack;
  assign b_pend   = b_req != b_req_ack;
  assign any_pend = a_pend | b_pend;
  assign mem_done = mem_req_ack == mem_req;

  // owner/last_grant encode the client: 0 = A, 1 = B
  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      a_pend && b_pend:
        pick_b = ROUND_ROBIN ? !last_grant : 1'b0;
      b_pend && !a_pend:
        pick_b = 1'b1;
      default:
        pick_b = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      mem_ds     <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      a_req_ack  <= 1'b0;
      b_req_ack  <= 1'b0;
      a_dout     <= '0;
      b_dout     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_pend) begin
            mem_addr   <= pick_b ? b_addr : a_addr;
            mem_ds     <= pick_b ? b_ds   : a_ds;
            mem_din    <= pick_b ? b_din  : a_din;
            mem_we     <= pick_b ? b_we   : a_we;
            mem_req    <= !mem_req;
            owner      <= pick_b;
            last_grant <= pick_b;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_done) begin
            if (owner) begin
              b_req_ack <= !b_req_ack;
              if (!mem_we) b_dout <= mem_dout;
            end else begin
              a_req_ack <= !a_req_ack;
              if (!mem_we) a_dout <= mem_dout;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: random + directed scoreboard bench for the
// two-client SDRAM port arbiter (round-robin and fixed-priority builds).
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [21:0] a_addr, b_addr, mem_addr;
  logic        a_req, b_req, a_we, b_we;
  logic        a_req_ack, b_req_ack;
  logic        mem_req, mem_we;
  logic        mem_req_ack = 1'b0;
  logic [1:0]  a_ds, b_ds, mem_ds;
  logic [15:0] a_din, b_din, a_dout, b_dout, mem_din;
  logic [15:0] mem_dout = 16'h0;

  sdram_port_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .a_addr(a_addr), .a_req(a_req), .a_ds(a_ds), .a_din(a_din),
    .a_we(a_we), .a_req_ack(a_req_ack), .a_dout(a_dout),
    .b_addr(b_addr), .b_req(b_req), .b_ds(b_ds), .b_din(b_din),
    .b_we(b_we), .b_req_ack(b_req_ack), .b_dout(b_dout),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ds(mem_ds),
    .mem_din(mem_din), .mem_we(mem_we),
    .mem_req_ack(mem_req_ack), .mem_dout(mem_dout)
  );

  // fixed-priority build, driven by its own tiny client/controller
  logic [21:0] f_a_addr = 22'h000010;
  logic [21:0] f_b_addr = 22'h200010;
  logic        f_a_req = 1'b0, f_b_req = 1'b0;
  logic        f_a_ack, f_b_ack;
  logic [15:0] f_a_dout, f_b_dout, f_mem_din;
  logic [21:0] f_mem_addr;
  logic        f_mem_req, f_mem_we;
  logic        f_mem_ack = 1'b0;
  logic [1:0]  f_mem_ds;
  logic [15:0] f_zero = 16'h0;

  sdram_port_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .resetn(resetn),
    .a_addr(f_a_addr), .a_req(f_a_req), .a_ds(2'b11), .a_din(f_zero),
    .a_we(1'b0), .a_req_ack(f_a_ack), .a_dout(f_a_dout),
    .b_addr(f_b_addr), .b_req(f_b_req), .b_ds(2'b11), .b_din(f_zero),
    .b_we(1'b0), .b_req_ack(f_b_ack), .b_dout(f_b_dout),
    .mem_addr(f_mem_addr), .mem_req(f_mem_req), .mem_ds(f_mem_ds),
    .mem_din(f_mem_din), .mem_we(f_mem_we),
    .mem_req_ack(f_mem_ack), .mem_dout(f_zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [21:0] ad);
    return ad[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] nw,
                                        input logic [1:0] ds);
    return {ds[1] ? nw[15:8] : old[15:8], ds[0] ? nw[7:0] : old[7:0]};
  endfunction

  // SDRAM controller model, acts on the falling edge
  logic [15:0] sdram [int];
  bit          c_busy = 0;
  int          c_cnt;
  int          c_delay = 1;
  bit          c_rand = 0;
  bit          c_hold_ok;
  logic [40:0] c_cmd;

  always @(negedge clk) begin
    if (!resetn) begin
      mem_req_ack = 1'b0;
      mem_dout    = 16'h0;
      c_busy      = 0;
    end else if (!c_busy) begin
      if (mem_req != mem_req_ack) begin
        c_busy    = 1;
        c_cnt     = c_rand ? int'($urandom_range(1, 6)) : c_delay;
        c_cmd     = {mem_addr, mem_we, mem_ds, mem_din};
        c_hold_ok = 1;
      end
    end else begin
      if ({mem_addr, mem_we, mem_ds, mem_din} !== c_cmd) c_hold_ok = 0;
      c_cnt--;
      if (c_cnt <= 0) begin
        logic [15:0] old;
        int k;
        k = int'(c_cmd[40:19]);
        old = sdram.exists(k) ? sdram[k] : init_val(c_cmd[40:19]);
        chk("mem_hold", c_hold_ok, 1);
        if (c_cmd[18]) sdram[k] = merge(old, c_cmd[15:0], c_cmd[17:16]);
        else mem_dout = old;
        mem_req_ack = ~mem_req_ack;
        c_busy = 0;
      end
    end
  end

  // reference model state
  logic [15:0] ref_mem [int];
  logic [15:0] last_dout [2];
  logic [15:0] exp_a[$], exp_b[$];
  logic [40:0] cur_req [2];
  bit          pend_a = 0, pend_b = 0, outst = 0;
  bit          owner_m = 0, last_win = 1;
  bit          grant_log[$];

  task automatic issue(input bit cl, input logic [21:0] ad, input bit we,
                       input logic [1:0] ds, input logic [15:0] din);
    logic [15:0] cur, e;
    int k;
    k = int'(ad);
    cur = ref_mem.exists(k) ? ref_mem[k] : init_val(ad);
    if (we) begin
      ref_mem[k] = merge(cur, din, ds);
      e = last_dout[cl];
    end else begin
      e = cur;
      last_dout[cl] = cur;
    end
    cur_req[cl] = {ad, we, ds, din};
    if (cl) begin
      exp_b.push_back(e);
      pend_b = 1;
      b_addr = ad; b_we = we; b_ds = ds; b_din = din;
      b_req = ~b_req;
    end else begin
      exp_a.push_back(e);
      pend_a = 1;
      a_addr = ad; a_we = we; a_ds = ds; a_din = din;
      a_req = ~a_req;
    end
  endtask

  // monitor: ack routing, read data, grant rules
  logic pa = 0, pb = 0, pmr = 0, pma = 0;
  bit   s_pa, s_pb, s_o, ta, tb, due, grant, w;

  always @(posedge clk) begin
    s_pa = pend_a;
    s_pb = pend_b;
    s_o  = outst;
    #1;
    if (!resetn) begin
      pa = 0; pb = 0; pmr = 0; pma = 0;
    end else begin
      due = mem_req_ack != pma;
      ta  = a_req_ack != pa;
      tb  = b_req_ack != pb;
      if (due || ta || tb)
        chk("ack_route", {ta, tb},
            due ? (owner_m ? 2'b01 : 2'b10) : 2'b00);
      if (ta) begin
        if (exp_a.size() == 0) chk("a_ack_unexpected", 1, 0);
        else chk("a_dout", a_dout, exp_a.pop_front());
        pend_a = 0;
        outst  = 0;
      end
      if (tb) begin
        if (exp_b.size() == 0) chk("b_ack_unexpected", 1, 0);
        else chk("b_dout", b_dout, exp_b.pop_front());
        pend_b = 0;
        outst  = 0;
      end
      grant = mem_req != pmr;
      if (grant) begin
        w = mem_addr[21];
        chk("one_outstanding", s_o, 0);
        chk("winner_pending", w ? s_pb : s_pa, 1);
        if (s_pa && s_pb) chk("rr_pick", w, !last_win);
        chk("grant_fields", {mem_addr, mem_we, mem_ds, mem_din},
            cur_req[w]);
        owner_m  = w;
        last_win = w;
        outst    = 1;
        grant_log.push_back(w);
      end else if (!s_o && (s_pa || s_pb)) begin
        chk("grant_latency", 0, 1);
      end
      pa = a_req_ack; pb = b_req_ack;
      pmr = mem_req; pma = mem_req_ack;
    end
  end

  // fixed-priority side: controller acks after two falling edges
  int  f_cnt = 0;
  int  fa_left = 0;
  logic f_pmr = 0;
  bit  fp_log[$];

  always @(negedge clk) begin
    if (!resetn) begin
      f_mem_ack = 1'b0;
      f_cnt = 0;
    end else if (f_mem_req != f_mem_ack) begin
      if (f_cnt == 1) begin
        f_mem_ack = f_mem_req;
        f_cnt = 0;
      end else f_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!resetn) f_pmr = 0;
    else begin
      if (f_mem_req != f_pmr) fp_log.push_back(f_mem_addr[21]);
      f_pmr = f_mem_req;
      if (fa_left > 0 && f_a_req == f_a_ack) begin
        f_a_req = ~f_a_req;
        fa_left--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((pend_a || pend_b || outst) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_done_in_time"}, n < 300, 1);
    tick();
  endtask

  task automatic wait_a();
    int n;
    n = 0;
    while (pend_a && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_a_timeout", 1, 0);
  endtask

  function automatic logic [3:0] log4();
    logic [3:0] v;
    v = '0;
    foreach (grant_log[i]) v = {v[2:0], grant_log[i]};
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lo, hi;
    resetn = 0;
    a_req = 0; b_req = 0;
    a_addr = '0; b_addr = '0; a_ds = '0; b_ds = '0;
    a_din = '0; b_din = '0; a_we = 0; b_we = 0;
    last_dout[0] = '0; last_dout[1] = '0;
    repeat (3) @(posedge clk);
    #3 resetn = 1;
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_a_ack", a_req_ack, 0);
    chk("rst_b_ack", b_req_ack, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_ds", mem_ds, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_b_dout", b_dout, 0);

    // single read A
    sdram[32'h100] = 16'hBEEF;
    ref_mem[32'h100] = 16'hBEEF;
    c_delay = 5;
    issue(0, 22'h000100, 0, 2'b11, 16'h0);
    @(posedge clk);
    #2;
    chk("rdA_mem_req", mem_req, 1);
    chk("rdA_mem_addr", mem_addr, 22'h000100);
    chk("rdA_mem_we", mem_we, 0);
    wait_idle("rdA");
    chk("rdA_dout", a_dout, 16'hBEEF);
    chk("rdA_b_ack", b_req_ack, b_req);

    // single write B, then read it back
    c_delay = 3;
    issue(1, 22'h200040, 1, 2'b01, 16'h1234);
    @(posedge clk);
    #2;
    chk("wrB_mem_we", mem_we, 1);
    chk("wrB_mem_din", mem_din, 16'h1234);
    chk("wrB_mem_ds", mem_ds, 2'b01);
    wait_idle("wrB");
    chk("wrB_dout_kept", b_dout, 16'h0000);
    issue(1, 22'h200040, 0, 2'b11, 16'h0);
    wait_idle("rdB");
    chk("rdB_merged", b_dout, 16'h5A34);

    // simultaneous requests, twice
    grant_log.delete();
    repeat (2) begin
      issue(0, 22'h000020, 0, 2'b11, 16'h0);
      issue(1, 22'h200020, 0, 2'b11, 16'h0);
      wait_idle("rr");
    end
    chk("rr_count", grant_log.size(), 4);
    chk("rr_order", log4(), 4'b0101);

    // late arrival while A is busy
    grant_log.delete();
    c_delay = 5;
    issue(0, 22'h000030, 0, 2'b11, 16'h0);
    tick();
    tick();
    issue(1, 22'h200030, 1, 2'b11, 16'hCAFE);
    wait_idle("late");
    chk("late_order", {grant_log.size() == 2, log4()}, {1'b1, 4'b0001});

    // 32-bit read as two halves while B streams writes
    c_rand = 1;
    fork
      begin
        issue(0, 22'h000008, 0, 2'b11, 16'h0);
        wait_a();
        lo = a_dout;
        issue(0, 22'h000009, 0, 2'b11, 16'h0);
        wait_a();
        hi = a_dout;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          int n;
          n = 0;
          while (pend_b && n < 200) begin tick(); n++; end
          issue(1, 22'h200000 | 22'(i), 1, 2'b11, 16'(i * 16'h1111));
          tick();
        end
      end
    join
    wait_idle("rv");
    chk("rv_rdata", {hi, lo}, {init_val(22'h9), init_val(22'h8)});

    // random traffic
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!pend_a && $urandom_range(0, 2) == 0)
        issue(0, 22'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 16'($urandom));
      if (!pend_b && $urandom_range(0, 2) == 0)
        issue(1, 22'h200000 | 22'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              16'($urandom));
    end
    wait_idle("rand");

    // reset in the middle of a B read
    c_rand = 0;
    c_delay = 8;
    issue(0, 22'h000050, 0, 2'b11, 16'h0);
    wait_idle("pre_rst");
    issue(1, 22'h200050, 0, 2'b11, 16'h0);
    tick();
    tick();
    tick();
    resetn = 0;
    a_req = 0; b_req = 0;
    pend_a = 0; pend_b = 0; outst = 0; last_win = 1;
    exp_a.delete(); exp_b.delete();
    last_dout[0] = '0; last_dout[1] = '0;
    @(posedge clk);
    #2;
    chk("mrst_mem_req", mem_req, 0);
    chk("mrst_a_ack", a_req_ack, 0);
    chk("mrst_b_ack", b_req_ack, 0);
    chk("mrst_mem_addr", mem_addr, 0);
    chk("mrst_a_dout", a_dout, 0);
    chk("mrst_b_dout", b_dout, 0);
    tick();
    resetn = 1;
    tick();
    c_delay = 2;
    issue(0, 22'h000060, 0, 2'b11, 16'h0);
    wait_idle("post_rst");
    chk("post_rst_dout", a_dout, init_val(22'h000060) ^ 16'h0
        | (ref_mem.exists(32'h60) ? ref_mem[32'h60] : 16'h0));

    // fixed priority: A kept pending four times, B waits
    fp_log.delete();
    fa_left = 4;
    tick();
    f_b_req = ~f_b_req;
    begin
      int n;
      n = 0;
      while (fp_log.size() < 5 && n < 300) begin tick(); n++; end
    end
    chk("fp_count", fp_log.size(), 5);
    for (int i = 0; i < 4; i++)
      if (i < fp_log.size()) chk("fp_a_wins", fp_log[i], 0);
    if (fp_log.size() >= 5) chk("fp_b_last", fp_log[4], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
